pixel_tap_line: RTL and testbench

//  Parametrised horizontal pixel tap line for the D8M video filter datapath.
//  - Shifts accepted pixels through TAPS registers and exposes every tap in parallel.
//  - Tracks how many pixels of the current video line the window holds.
//  - Flags when the window is fully populated, so downstream kernels (blur, edge) know when to compute.

---
 rtl/video_pkg.sv | 9 +
 rtl/tap_fill_ctr.sv | 78 +++++++
 rtl/pixel_tap_line.sv | 84 ++++++++
 tb/tb_pixel_tap_line.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared video datapath definitions: default pixel width, default tap count and the pixel type.
package video_pkg;

    localparam int unsigned PIX_W_DEF = 24;
    localparam int unsigned TAPS_DEF  = 11;

    typedef logic [PIX_W_DEF-1:0] pixel_t;

endpackage

// File: rtl/tap_fill_ctr.sv
// Fill tracking for the tap line: saturating pixel count, line-start detection and taps_valid.
// With TAP_EDGE_REPLICATE_EN defined, also reports when a line start should load every tap.
module tap_fill_ctr
    import video_pkg::*;
#(
    parameter int unsigned TAPS = TAPS_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       accept,
    input  logic                       sol,
`ifdef TAP_EDGE_REPLICATE_EN
    output logic                       load_all,
`endif
    output logic [$clog2(TAPS+1)-1:0]  fill_cnt,
    output logic                       taps_valid
);

    localparam int unsigned CNT_W = $clog2(TAPS + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(TAPS);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q;
    logic             line_start;

`ifdef TAP_EDGE_REPLICATE_EN
    localparam logic [CNT_W-1:0] START = FULL;

    // First accept after reset or flush starts a line even without sol.
    logic fresh_q;

    assign line_start = sol | fresh_q;
    assign load_all   = accept & line_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fresh_q <= 1'b1;
        end else if (flush) begin
            fresh_q <= 1'b1;
        end else if (accept) begin
            fresh_q <= 1'b0;
        end
    end
`else
    localparam logic [CNT_W-1:0] START = CNT_W'(1);

    // After reset or flush the count is 0, so the first accept yields 1 with or without sol.
    assign line_start = sol;
`endif

    always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else if (accept) begin
            if (line_start) begin
                cnt_d = START;
            end else if (cnt_q != FULL) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            valid_q <= (cnt_d == FULL);
        end
    end

    assign fill_cnt   = cnt_q;
    assign taps_valid = valid_q;

endmodule

// File: rtl/pixel_tap_line.sv
// Horizontal pixel tap line: TAPS-deep shift register with parallel taps, centre tap and fill state.
// Optional edge replication on line start is enabled by defining TAP_EDGE_REPLICATE_EN.
module pixel_tap_line
    import video_pkg::*;
#(
    parameter int unsigned PIX_W = PIX_W_DEF,
    parameter int unsigned TAPS  = TAPS_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [PIX_W-1:0]           pixel,
    input  logic                       pix_valid,
    input  logic                       sol,
    input  logic                       flush,
    output logic [TAPS*PIX_W-1:0]      taps,
    output logic [PIX_W-1:0]           center,
    output logic                       taps_valid,
    output logic [$clog2(TAPS+1)-1:0]  fill_cnt
);

    localparam int unsigned CTR = TAPS / 2;

    logic             accept;
    logic [PIX_W-1:0] center_q;

    // flush wins over a pixel presented in the same cycle.
    assign accept = pix_valid & ~flush;

`ifdef TAP_EDGE_REPLICATE_EN
    logic load_all;
`endif

    tap_fill_ctr #(
        .TAPS (TAPS)
    ) u_fill (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .accept     (accept),
        .sol        (sol),
`ifdef TAP_EDGE_REPLICATE_EN
        .load_all   (load_all),
`endif
        .fill_cnt   (fill_cnt),
        .taps_valid (taps_valid)
    );

    for (genvar k = 0; k < TAPS; k++) begin : g_tap
        logic [PIX_W-1:0] q, d, shift_in;

        if (k == 0) begin : g_head
            assign shift_in = pixel;
        end else begin : g_body
            assign shift_in = g_tap[k-1].q;
        end

`ifdef TAP_EDGE_REPLICATE_EN
        assign d = flush ? '0 : load_all ? pixel : accept ? shift_in : q;
`else
        assign d = flush ? '0 : accept ? shift_in : q;
`endif

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q <= '0;
            end else begin
                q <= d;
            end
        end

        assign taps[k*PIX_W +: PIX_W] = q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            center_q <= '0;
        end else begin
            center_q <= g_tap[CTR].d;
        end
    end

    assign center = center_q;

endmodule

// File: tb/tb_pixel_tap_line.sv
// Directed table-driven bench for pixel_tap_line (PIX_W=24, TAPS=11), both build configurations.
module tb_pixel_tap_line;
    import video_pkg::*;

    localparam int unsigned PW = 24;
    localparam int unsigned NT = 11;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [PW-1:0]     pixel = '0;
    logic              pix_valid = 1'b0;
    logic              sol = 1'b0;
    logic              flush = 1'b0;
    logic [NT*PW-1:0]  taps;
    logic [PW-1:0]     center;
    logic              taps_valid;
    logic [3:0]        fill_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    pixel_tap_line #(
        .PIX_W (PW),
        .TAPS  (NT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pixel      (pixel),
        .pix_valid  (pix_valid),
        .sol        (sol),
        .flush      (flush),
        .taps       (taps),
        .center     (center),
        .taps_valid (taps_valid),
        .fill_cnt   (fill_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic   v;
        logic   s;
        logic   f;
        pixel_t px;
        int     fill;
        logic   valid;
        pixel_t t0;
        pixel_t t1;
        pixel_t ctr;
        pixel_t tlast;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic v, logic s, logic f, pixel_t px, int fill, logic valid,
                                pixel_t t0, pixel_t t1, pixel_t ctr, pixel_t tlast);
        vec_t r;
        r.v = v; r.s = s; r.f = f; r.px = px; r.fill = fill; r.valid = valid;
        r.t0 = t0; r.t1 = t1; r.ctr = ctr; r.tlast = tlast;
        return r;
    endfunction

    function automatic pixel_t tap(int k);
        return taps[k*PW +: PW];
    endfunction

    task automatic check(string name, longint act, longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply(logic v, logic s, logic f, pixel_t px);
        @(negedge clk);
        pix_valid = v; sol = s; flush = f; pixel = px;
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(string tag);
        check({tag, " taps"}, (taps == '0) ? 1 : 0, 1);
        check({tag, " center"}, center, 0);
        check({tag, " taps_valid"}, taps_valid, 0);
        check({tag, " fill_cnt"}, fill_cnt, 0);
    endtask

    initial begin
`ifndef TAP_EDGE_REPLICATE_EN
        // Line fill 1..B with a 0,0 gap after pixel 3; sol ignored while pix_valid is low.
        tbl.push_back(mk(1, 1, 0, 24'h1,  1, 0, 24'h1, 24'h0, 24'h0, 24'h0));
        tbl.push_back(mk(1, 0, 0, 24'h2,  2, 0, 24'h2, 24'h1, 24'h0, 24'h0));
        tbl.push_back(mk(1, 0, 0, 24'h3,  3, 0, 24'h3, 24'h2, 24'h0, 24'h0));
        tbl.push_back(mk(0, 0, 0, 24'h77, 3, 0, 24'h3, 24'h2, 24'h0, 24'h0));
        tbl.push_back(mk(0, 1, 0, 24'h78, 3, 0, 24'h3, 24'h2, 24'h0, 24'h0));
        tbl.push_back(mk(1, 0, 0, 24'h4,  4, 0, 24'h4, 24'h3, 24'h0, 24'h0));
        tbl.push_back(mk(1, 0, 0, 24'h5,  5, 0, 24'h5, 24'h4, 24'h0, 24'h0));
        tbl.push_back(mk(1, 0, 0, 24'h6,  6, 0, 24'h6, 24'h5, 24'h1, 24'h0));
        tbl.push_back(mk(1, 0, 0, 24'h7,  7, 0, 24'h7, 24'h6, 24'h2, 24'h0));
        tbl.push_back(mk(1, 0, 0, 24'h8,  8, 0, 24'h8, 24'h7, 24'h3, 24'h0));
        tbl.push_back(mk(1, 0, 0, 24'h9,  9, 0, 24'h9, 24'h8, 24'h4, 24'h0));
        tbl.push_back(mk(1, 0, 0, 24'hA, 10, 0, 24'hA, 24'h9, 24'h5, 24'h0));
        tbl.push_back(mk(1, 0, 0, 24'hB, 11, 1, 24'hB, 24'hA, 24'h6, 24'h1));
        // Saturation, then a new line leaves old pixels in the upper taps.
        tbl.push_back(mk(1, 0, 0, 24'hC, 11, 1, 24'hC, 24'hB, 24'h7, 24'h2));
        tbl.push_back(mk(1, 1, 0, 24'hFF0000, 1, 0, 24'hFF0000, 24'hC, 24'h8, 24'h3));
        tbl.push_back(mk(1, 0, 0, 24'h21, 2, 0, 24'h21, 24'hFF0000, 24'h9, 24'h4));
        // flush drops the concurrent sol pixel; next accept restarts at 1.
        tbl.push_back(mk(1, 1, 1, 24'h99, 0, 0, 24'h0, 24'h0, 24'h0, 24'h0));
        tbl.push_back(mk(1, 0, 0, 24'h55, 1, 0, 24'h55, 24'h0, 24'h0, 24'h0));
`else
        tbl.push_back(mk(1, 1, 0, 24'h123456, 11, 1, 24'h123456, 24'h123456, 24'h123456,
                         24'h123456));
        tbl.push_back(mk(1, 0, 0, 24'h1, 11, 1, 24'h1, 24'h123456, 24'h123456, 24'h123456));
        tbl.push_back(mk(0, 0, 0, 24'h2, 11, 1, 24'h1, 24'h123456, 24'h123456, 24'h123456));
        tbl.push_back(mk(1, 1, 0, 24'hAA, 11, 1, 24'hAA, 24'hAA, 24'hAA, 24'hAA));
        tbl.push_back(mk(1, 1, 1, 24'h99, 0, 0, 24'h0, 24'h0, 24'h0, 24'h0));
        tbl.push_back(mk(1, 0, 0, 24'h33, 11, 1, 24'h33, 24'h33, 24'h33, 24'h33));
        tbl.push_back(mk(1, 0, 0, 24'h44, 11, 1, 24'h44, 24'h33, 24'h33, 24'h33));
`endif

        #12;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            apply(tbl[i].v, tbl[i].s, tbl[i].f, tbl[i].px);
            check($sformatf("vec%0d fill_cnt", i), fill_cnt, tbl[i].fill);
            check($sformatf("vec%0d taps_valid", i), taps_valid, tbl[i].valid);
            check($sformatf("vec%0d tap0", i), tap(0), tbl[i].t0);
            check($sformatf("vec%0d tap1", i), tap(1), tbl[i].t1);
            check($sformatf("vec%0d center", i), center, tbl[i].ctr);
            check($sformatf("vec%0d tap10", i), tap(NT-1), tbl[i].tlast);
        end

`ifdef TAP_EDGE_REPLICATE_EN
        apply(1, 1, 0, 24'h123456);
        for (int k = 0; k < NT; k++) begin
            check($sformatf("replicate tap%0d", k), tap(k), 24'h123456);
        end
`else
        // Run a long line so the window is full before the mid-line reset.
        for (int k = 0; k < 20; k++) begin
            apply(1, 0, 0, pixel_t'(k + 'h100));
        end
        check("long line fill_cnt", fill_cnt, NT);
        check("long line taps_valid", taps_valid, 1);
`endif

        // Asynchronous reset mid-cycle, away from any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async reset");
        @(negedge clk);
        pix_valid = 1'b0;
        rst_n = 1'b1;
        apply(1, 0, 0, 24'h42);
        check("post-reset tap0", tap(0), 24'h42);
`ifdef TAP_EDGE_REPLICATE_EN
        check("post-reset fill_cnt", fill_cnt, NT);
        check("post-reset taps_valid", taps_valid, 1);
        check("post-reset center", center, 24'h42);
`else
        check("post-reset fill_cnt", fill_cnt, 1);
        check("post-reset taps_valid", taps_valid, 0);
        check("post-reset center", center, 0);
`endif

        apply(0, 0, 0, 24'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
